// File: rtl/rv32i_pkg.sv
// Shared register-file constants and writeback arbitration types.
package rv32i_pkg;
  localparam int DataWidth    = 32;
  localparam int Registers    = 32;
  localparam int AddrRegWidth = 5;

  typedef enum logic {PRIO_A, FORCE_B} arb_state_e;

  typedef struct packed {
    logic [AddrRegWidth-1:0] rd;
    logic [DataWidth-1:0]    wdata;
  } wb_req_t;
endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard for long-latency results; clears land on the
// register-file commit edge, one cycle after the B handshake.
module wb_scoreboard #(
  parameter int Registers    = 32,
  parameter int AddrRegWidth = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sb_set,
  input  logic [AddrRegWidth-1:0] sb_set_rd,
  input  logic                    b_xfer,
  input  logic [AddrRegWidth-1:0] b_rd,
  input  logic [AddrRegWidth-1:0] q_rs1,
  input  logic [AddrRegWidth-1:0] q_rs2,
  output logic                    q_rs1_busy,
  output logic                    q_rs2_busy,
  output logic                    sb_err
);
  import rv32i_pkg::*;

  logic [Registers-1:0]    pending;
  logic                    clr_vld;
  logic [AddrRegWidth-1:0] clr_rd;
  logic                    set_hit, set_err, b_err;

  // A bit whose clear lands on this edge no longer counts as pending.
  always_comb begin
    set_hit = sb_set && (sb_set_rd != '0);
    set_err = set_hit && pending[sb_set_rd] && !(clr_vld && clr_rd == sb_set_rd);
    b_err   = b_xfer && (b_rd != '0) &&
              (!pending[b_rd] || (clr_vld && clr_rd == b_rd));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      clr_vld <= 1'b0;
      clr_rd  <= '0;
      sb_err  <= 1'b0;
    end else begin
      clr_vld <= b_xfer && (b_rd != '0);
      clr_rd  <= b_rd;
      if (clr_vld) pending[clr_rd]    <= 1'b0;
      if (set_hit) pending[sb_set_rd] <= 1'b1;
      if (set_err || b_err) sb_err <= 1'b1;
    end
  end

  assign q_rs1_busy = (q_rs1 != '0) && pending[q_rs1];
  assign q_rs2_busy = (q_rs2 != '0) && pending[q_rs2];
endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between pipeline (A) and long-latency
// (B) writebacks; A has priority until B has starved StarveLimit cycles.
module wb_port_arbiter #(
  parameter int DataWidth    = 32,
  parameter int Registers    = 32,
  parameter int AddrRegWidth = 5,
  parameter int StarveLimit  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    a_valid,
  output logic                    a_ready,
  input  logic [AddrRegWidth-1:0] a_rd,
  input  logic [DataWidth-1:0]    a_wdata,
  input  logic                    b_valid,
  output logic                    b_ready,
  input  logic [AddrRegWidth-1:0] b_rd,
  input  logic [DataWidth-1:0]    b_wdata,
  input  logic                    sb_set,
  input  logic [AddrRegWidth-1:0] sb_set_rd,
  input  logic [AddrRegWidth-1:0] q_rs1,
  input  logic [AddrRegWidth-1:0] q_rs2,
  output logic                    q_rs1_busy,
  output logic                    q_rs2_busy,
  output logic                    rf_wen,
  output logic [AddrRegWidth-1:0] rf_rd,
  output logic [DataWidth-1:0]    rf_wdata,
  output logic                    sb_err
);
  import rv32i_pkg::*;

  localparam logic [3:0] StarveMax = 4'(StarveLimit - 1);

  arb_state_e state;
  logic [3:0] starve_cnt;
  logic       a_xfer, b_xfer, b_lose;
  wb_req_t    win;

  always_comb begin
    a_ready = !rst && ((state == PRIO_A) ? 1'b1 : !b_valid);
    b_ready = !rst && ((state == PRIO_A) ? !a_valid : 1'b1);
    a_xfer  = a_valid && a_ready;
    b_xfer  = b_valid && b_ready;
    b_lose  = b_valid && !b_ready;
    win     = a_xfer ? '{rd: a_rd, wdata: a_wdata} : '{rd: b_rd, wdata: b_wdata};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= PRIO_A;
      starve_cnt <= '0;
      rf_wen     <= 1'b0;
      rf_rd      <= '0;
      rf_wdata   <= '0;
    end else begin
      if (!b_lose)                  starve_cnt <= '0;
      else if (starve_cnt != 4'hF)  starve_cnt <= starve_cnt + 4'd1;
      case (state)
        PRIO_A:  if (b_lose && starve_cnt == StarveMax) state <= FORCE_B;
        FORCE_B: if (b_xfer || !b_valid)                state <= PRIO_A;
        default:                                        state <= PRIO_A;
      endcase
      // x0 writes complete the handshake but never reach the register file.
      rf_wen <= (a_xfer || b_xfer) && (win.rd != '0);
      if (a_xfer || b_xfer) begin
        rf_rd    <= win.rd;
        rf_wdata <= win.wdata;
      end
    end
  end

  wb_scoreboard #(.Registers(Registers), .AddrRegWidth(AddrRegWidth)) u_sb (
    .clk        (clk),
    .rst        (rst),
    .sb_set     (sb_set),
    .sb_set_rd  (sb_set_rd),
    .b_xfer     (b_xfer),
    .b_rd       (b_rd),
    .q_rs1      (q_rs1),
    .q_rs2      (q_rs2),
    .q_rs1_busy (q_rs1_busy),
    .q_rs2_busy (q_rs2_busy),
    .sb_err     (sb_err)
  );
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: reset, priority, starvation, scoreboard.
module tb_wb_port_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, a_ready, b_valid, b_ready;
  logic [4:0]  a_rd, b_rd, sb_set_rd, q_rs1, q_rs2, rf_rd;
  logic [31:0] a_wdata, b_wdata, rf_wdata;
  logic        sb_set, q_rs1_busy, q_rs2_busy, rf_wen, sb_err;
  int          vec = 0;
  int          miss = 0;

  always #5 clk = ~clk;

  wb_port_arbiter #(.StarveLimit(4)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_wdata(a_wdata),
    .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_wdata(b_wdata),
    .sb_set(sb_set), .sb_set_rd(sb_set_rd),
    .q_rs1(q_rs1), .q_rs2(q_rs2), .q_rs1_busy(q_rs1_busy), .q_rs2_busy(q_rs2_busy),
    .rf_wen(rf_wen), .rf_rd(rf_rd), .rf_wdata(rf_wdata), .sb_err(sb_err)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick();
    rst = 1'b0; sb_set = 1'b1; sb_set_rd = 5'd3; tick();
    sb_set = 1'b0; q_rs1 = 5'd3; #1;
    vec++; if (q_rs1_busy !== 1'b1) begin miss++; $display("FAIL pre_rst_busy got %0b want 1", q_rs1_busy); end
    rst = 1'b1; a_valid = 1'b1; b_valid = 1'b1; b_rd = 5'd3; #1;
    vec++; if (b_ready !== 1'b0) begin miss++; $display("FAIL rst_b_ready got %0b want 0", b_ready); end
    vec++; if (a_ready !== 1'b0) begin miss++; $display("FAIL rst_a_ready got %0b want 0", a_ready); end
    tick();
    vec++; if (rf_wen !== 1'b0) begin miss++; $display("FAIL rst_rf_wen got %0b want 0", rf_wen); end
    vec++; if (rf_rd !== 5'd0 || rf_wdata !== 32'd0) begin miss++; $display("FAIL rst_rf got rd=%0d data=%h want 0/0", rf_rd, rf_wdata); end
    vec++; if (q_rs1_busy !== 1'b0 || q_rs2_busy !== 1'b0) begin miss++; $display("FAIL rst_busy got %0b%0b want 00", q_rs1_busy, q_rs2_busy); end
    vec++; if (sb_err !== 1'b0) begin miss++; $display("FAIL rst_sb_err got %0b want 0", sb_err); end
    rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0; tick();
  endtask

  task automatic test_a_alone();
    a_valid = 1'b1; a_rd = 5'd5; a_wdata = 32'hDEADBEEF; q_rs1 = 5'd5; #1;
    vec++; if (a_ready !== 1'b1) begin miss++; $display("FAIL a_ready got %0b want 1", a_ready); end
    tick(); a_valid = 1'b0;
    vec++; if (rf_wen !== 1'b1 || rf_rd !== 5'd5 || rf_wdata !== 32'hDEADBEEF) begin miss++; $display("FAIL a_write got wen=%0b rd=%0d data=%h want 1/5/deadbeef", rf_wen, rf_rd, rf_wdata); end
    vec++; if (q_rs1_busy !== 1'b0) begin miss++; $display("FAIL a_busy got %0b want 0", q_rs1_busy); end
    tick();
    vec++; if (rf_wen !== 1'b0 || rf_rd !== 5'd5 || rf_wdata !== 32'hDEADBEEF) begin miss++; $display("FAIL a_hold got wen=%0b rd=%0d data=%h want 0/5/deadbeef", rf_wen, rf_rd, rf_wdata); end
  endtask

  task automatic test_contention();
    sb_set = 1'b1; sb_set_rd = 5'd7; tick(); sb_set = 1'b0;
    a_valid = 1'b1; a_rd = 5'd1; a_wdata = 32'h11;
    b_valid = 1'b1; b_rd = 5'd7; b_wdata = 32'h77; q_rs2 = 5'd7;
    for (int i = 0; i < 4; i++) begin
      #1;
      vec++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin miss++; $display("FAIL lose%0d got a=%0b b=%0b want 1/0", i, a_ready, b_ready); end
      tick();
      vec++; if (rf_wen !== 1'b1 || rf_rd !== 5'd1) begin miss++; $display("FAIL a_win%0d got wen=%0b rd=%0d want 1/1", i, rf_wen, rf_rd); end
    end
    #1;
    vec++; if (a_ready !== 1'b0 || b_ready !== 1'b1) begin miss++; $display("FAIL force_b got a=%0b b=%0b want 0/1", a_ready, b_ready); end
    tick(); b_valid = 1'b0; #1;
    vec++; if (rf_wen !== 1'b1 || rf_rd !== 5'd7 || rf_wdata !== 32'h77) begin miss++; $display("FAIL b_write got wen=%0b rd=%0d data=%h want 1/7/77", rf_wen, rf_rd, rf_wdata); end
    vec++; if (q_rs2_busy !== 1'b1) begin miss++; $display("FAIL r7_at_commit got %0b want 1", q_rs2_busy); end
    vec++; if (a_ready !== 1'b1) begin miss++; $display("FAIL back_prio_a got %0b want 1", a_ready); end
    tick(); a_valid = 1'b0;
    vec++; if (q_rs2_busy !== 1'b0) begin miss++; $display("FAIL r7_cleared got %0b want 0", q_rs2_busy); end
    vec++; if (rf_rd !== 5'd1 || sb_err !== 1'b0) begin miss++; $display("FAIL after_b got rd=%0d err=%0b want 1/0", rf_rd, sb_err); end
    tick();
  endtask

  task automatic test_scoreboard();
    sb_set = 1'b1; sb_set_rd = 5'd9; q_rs2 = 5'd9; tick(); sb_set = 1'b0; #1;
    vec++; if (q_rs2_busy !== 1'b1) begin miss++; $display("FAIL r9_set got %0b want 1", q_rs2_busy); end
    b_valid = 1'b1; b_rd = 5'd9; b_wdata = 32'h99; #1;
    vec++; if (b_ready !== 1'b1) begin miss++; $display("FAIL b9_ready got %0b want 1", b_ready); end
    tick(); b_valid = 1'b0; sb_set = 1'b1; sb_set_rd = 5'd9;
    vec++; if (rf_wen !== 1'b1 || rf_rd !== 5'd9) begin miss++; $display("FAIL b9_write got wen=%0b rd=%0d want 1/9", rf_wen, rf_rd); end
    tick(); sb_set = 1'b0; #1;
    vec++; if (q_rs2_busy !== 1'b1) begin miss++; $display("FAIL set_wins got %0b want 1", q_rs2_busy); end
    vec++; if (sb_err !== 1'b0) begin miss++; $display("FAIL set_clr_err got %0b want 0", sb_err); end
    b_valid = 1'b1; tick(); b_valid = 1'b0; tick();
    vec++; if (q_rs2_busy !== 1'b0 || sb_err !== 1'b0) begin miss++; $display("FAIL r9_final got busy=%0b err=%0b want 0/0", q_rs2_busy, sb_err); end
  endtask

  task automatic test_x0_err();
    b_valid = 1'b1; b_rd = 5'd0; b_wdata = 32'h55; #1;
    vec++; if (b_ready !== 1'b1) begin miss++; $display("FAIL x0_ready got %0b want 1", b_ready); end
    tick(); b_valid = 1'b0;
    vec++; if (rf_wen !== 1'b0) begin miss++; $display("FAIL x0_wen got %0b want 0", rf_wen); end
    tick();
    b_valid = 1'b1; b_rd = 5'd3; b_wdata = 32'h33; tick(); b_valid = 1'b0;
    vec++; if (rf_wen !== 1'b1 || rf_rd !== 5'd3 || rf_wdata !== 32'h33) begin miss++; $display("FAIL err_write got wen=%0b rd=%0d data=%h want 1/3/33", rf_wen, rf_rd, rf_wdata); end
    vec++; if (sb_err !== 1'b1) begin miss++; $display("FAIL err_set got %0b want 1", sb_err); end
    tick(); tick(); tick();
    vec++; if (sb_err !== 1'b1) begin miss++; $display("FAIL err_sticky got %0b want 1", sb_err); end
  endtask

  task automatic test_idle();
    for (int i = 0; i < 10; i++) begin
      tick();
      vec++; if (rf_wen !== 1'b0) begin miss++; $display("FAIL idle%0d_wen got %0b want 0", i, rf_wen); end
    end
    // Fresh count: B must lose exactly four times again before it is forced in.
    a_valid = 1'b1; a_rd = 5'd2; a_wdata = 32'h22; b_valid = 1'b1; b_rd = 5'd0;
    for (int i = 0; i < 4; i++) begin
      #1;
      vec++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin miss++; $display("FAIL idle_lose%0d got a=%0b b=%0b want 1/0", i, a_ready, b_ready); end
      tick();
    end
    #1;
    vec++; if (b_ready !== 1'b1 || a_ready !== 1'b0) begin miss++; $display("FAIL idle_force got a=%0b b=%0b want 0/1", a_ready, b_ready); end
    b_valid = 1'b0; #1;
    vec++; if (a_ready !== 1'b1) begin miss++; $display("FAIL force_drop_a got %0b want 1", a_ready); end
    tick(); b_valid = 1'b1; #1;
    vec++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin miss++; $display("FAIL exit_force got a=%0b b=%0b want 1/0", a_ready, b_ready); end
    a_valid = 1'b0; b_valid = 1'b0; tick();
  endtask

  initial begin
    rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0; sb_set = 1'b0;
    a_rd = '0; b_rd = '0; sb_set_rd = '0; q_rs1 = '0; q_rs2 = '0;
    a_wdata = '0; b_wdata = '0;
    test_reset();
    test_a_alone();
    test_contention();
    test_scoreboard();
    test_x0_err();
    test_idle();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Owns the single write port of the 32x32 integer register file and shares it between two requesters.
  - Port A: the in-order pipeline writeback (ALU, jump link).
  - Port B: the long-latency unit writeback (load/store unit or mul/div).
- Registers the winning write onto rf_wen/rf_rd/rf_wdata.
- Keeps a per-register pending scoreboard that issue logic queries for RAW/WAW hazards on long-latency results.
- Bounds starvation of port B with an age counter and a two-state FSM.

Parameters:
DataWidth, 32, register data width
Registers, 32, number of architectural registers
AddrRegWidth, 5, register index width
StarveLimit, 4, consecutive cycles B may lose before A is forced to stall (1..15)

Ports:
clk  input  1  clock
rst  input  1  reset
a_valid  input  1  pipeline writeback request
a_ready  output  1  pipeline write accepted this cycle
a_rd  input  AddrRegWidth  pipeline destination
a_wdata  input  DataWidth  pipeline data
b_valid  input  1  long-latency writeback request
b_ready  output  1  long-latency write accepted this cycle
b_rd  input  AddrRegWidth  long-latency destination
b_wdata  input  DataWidth  long-latency data
sb_set  input  1  long-latency op issued, mark sb_set_rd pending
sb_set_rd  input  AddrRegWidth  destination of issued op
q_rs1  input  AddrRegWidth  scoreboard query 1
q_rs2  input  AddrRegWidth  scoreboard query 2
q_rs1_busy  output  1  q_rs1 has pending long-latency write
q_rs2_busy  output  1  q_rs2 has pending long-latency write
rf_wen  output  1  register file write enable
rf_rd  output  AddrRegWidth  register file write index
rf_wdata  output  DataWidth  register file write data
sb_err  output  1  sticky: set on already-pending reg, or B write to non-pending reg

Behaviour:
- Reset: rst is synchronous and active-high; clk is the clock.
  - While rst is high: rf_wen=0, rf_rd=0, rf_wdata=0, all pending bits 0, starve_cnt=0, state=PRIO_A, sb_err=0.
  - a_ready and b_ready are forced to 0 while rst is high, including reset asserted mid-operation. In-flight requests are dropped.
- FSM state PRIO_A:
  - a_ready = 1.
  - b_ready = !a_valid.
- FSM state FORCE_B:
  - b_ready = 1.
  - a_ready = !b_valid. The pipeline treats !a_ready as a stall and holds its request stable.
- Handshake: a transfer occurs when valid && ready is true at the rising edge. At most one transfer per cycle.
- Starvation counter:
  - starve_cnt increments when b_valid && !b_ready; otherwise it clears to 0.
  - PRIO_A -> FORCE_B when starve_cnt == StarveLimit-1 and B loses again.
  - FORCE_B -> PRIO_A on a B transfer, or when b_valid is low.
  - The count saturates and does not wrap.
- Write port: registered, one-cycle latency.
  - The transfer at edge T drives rf_wen=1 with the winner's rd/data during cycle T+1; the register file commits at edge T+1.
  - With no transfer, rf_wen=0 and rf_rd/rf_wdata hold their previous values.
- rd=0: the handshake completes normally, but rf_wen stays 0. x0 is never pending.
- Scoreboard: 32 pending bits.
  - sb_set marks sb_set_rd pending at the edge.
  - A B transfer clears b_rd's bit at edge T+1, coincident with the register file commit.
  - Set and clear of the same register at the same edge: set wins.
  - Set on an already-pending register, or a B transfer to a non-pending rd: set sb_err (sticky until rst) and otherwise proceed normally.
  - A-port writes never touch pending bits.
- Queries are combinational from the pending bits. Index 0 always returns 0.

Decomposition:
- rv32i_pkg holds:
  - DataWidth/Registers/AddrRegWidth constants.
  - The arb_state_e enum {PRIO_A, FORCE_B}.
  - A wb_req_t struct {rd, wdata}.
- One sub-module, wb_scoreboard: holds the pending bits, set/clear priority, query ports and sb_err.
- The arbiter FSM, starvation counter and output register stay in the top.

Test Plan:
- Reset mid-transfer: b_valid=1 with rst=1 -> b_ready=0; next cycle rf_wen=0 and all q_*_busy=0.
- A alone, a_rd=5, a_wdata=0xDEADBEEF -> a_ready=1; next cycle rf_wen=1, rf_rd=5, rf_wdata=0xDEADBEEF; q_rs1=5 busy=0.
- Contention with StarveLimit=4: a_valid held 1, b_valid=1, b_rd=7 -> B loses 4 cycles; 5th cycle a_ready=0, b_ready=1; r7 pending bit clears one cycle after the grant.
- Scoreboard: sb_set rd=9 -> q_rs2=9 busy=1. B writes rd=9 with sb_set rd=9 on the same clear edge -> still busy=1, sb_err=0.
- x0 and error path: B transfer rd=0 -> rf_wen=0, b_ready=1. B transfer to non-pending rd=3 -> write occurs, sb_err=1 and stays 1.
- Idle: no valids for 10 cycles -> rf_wen=0, state PRIO_A, starve_cnt=0.
